// File: rtl/snn_pkg.sv
// Shared definitions for the spiking controller and its downstream stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

  // Default spike vector width and per-neuron counter width. The controller
  // uses the same values, so both sides of the spike interface agree.
  localparam int SNN_N_NEURONS = 8;
  localparam int SNN_CNT_W     = 8;

  // Window decoder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    HOLD   = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of per-neuron saturating spike counters with an indexed read port.
// Latency: counts update on the edge after en_i; rd_cnt_o reads the registered counts.
// Backpressure: none; clr_i takes priority over en_i.
//
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clr_i        : zero every counter
//   en_i         : add spike_i[i] to counter i (saturating)
//   spike_i      : one timestep of spikes, bit i = neuron i
//   rd_idx_i     : neuron index to read
//   rd_cnt_o     : count of neuron rd_idx_i
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int N_NEURONS = SNN_N_NEURONS,
  parameter int CNT_W     = SNN_CNT_W,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [N_NEURONS-1:0] spike_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o
);

  logic [CNT_W-1:0] cnt_q [N_NEURONS];
  logic [CNT_W-1:0] cnt_d [N_NEURONS];

  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
      end else if (en_i && spike_i[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        // All-ones is the ceiling: a full counter simply holds.
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/spike_window_decoder.sv
// Counts spikes per neuron over WINDOW valid timesteps, then picks the winner by sequential scan.
// Latency: result_valid rises N_NEURONS+1 cycles after the last accepted sample.
// Backpressure: result held in HOLD until result_ready; start is ignored outside IDLE.
//
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start                 : begin a window (IDLE only)
//   spike_in, spike_valid : one timestep of spikes (COUNT only)
//   busy                  : high while counting or scanning
//   result_valid/_ready   : result handshake
//   class_out, class_count: winning neuron and its count
//   no_spike              : every count was zero (class_out forced to 0)
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS = SNN_N_NEURONS,
  parameter int CNT_W     = SNN_CNT_W,
  parameter int WINDOW    = 16,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [IDX_W-1:0]     class_out,
  output logic [CNT_W-1:0]     class_count,
  output logic                 no_spike
);

  localparam int                STEP_W    = $clog2(WINDOW + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURONS - 1);

  dec_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  class_q, class_d;
  logic [CNT_W-1:0]  ccnt_q, ccnt_d;
  logic              nospk_q, nospk_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  rd_cnt;
  logic [IDX_W-1:0]  cand_idx;
  logic [CNT_W-1:0]  cand_cnt;

  spike_counter_bank #(
    .N_NEURONS (N_NEURONS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .spike_i  (spike_in),
    .rd_idx_i (scan_q),
    .rd_cnt_o (rd_cnt)
  );

  // Best-so-far including the index under scan this cycle. Strict '>' keeps
  // the earlier (lower) index on ties; index 0 always seeds the search.
  always_comb begin
    cand_idx = best_idx_q;
    cand_cnt = best_cnt_q;
    if ((scan_q == '0) || (rd_cnt > best_cnt_q)) begin
      cand_idx = scan_q;
      cand_cnt = rd_cnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    class_d    = class_q;
    ccnt_d     = ccnt_q;
    nospk_d    = nospk_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          step_d     = '0;
          scan_d     = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          class_d    = '0;
          ccnt_d     = '0;
          nospk_d    = 1'b0;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        if (spike_valid) begin
          cnt_en = 1'b1;
          step_d = step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            scan_d  = '0;
            state_d = ARGMAX;
          end
        end
      end
      ARGMAX: begin
        best_idx_d = cand_idx;
        best_cnt_d = cand_cnt;
        scan_d     = scan_q + IDX_W'(1);
        if (scan_q == LAST_IDX) begin
          // Result registers load directly from the final candidate so the
          // outputs are valid in the first HOLD cycle.
          class_d = (cand_cnt == '0) ? '0 : cand_idx;
          ccnt_d  = cand_cnt;
          nospk_d = (cand_cnt == '0);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == COUNT) || (state_d == ARGMAX);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      class_q    <= '0;
      ccnt_q     <= '0;
      nospk_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      class_q    <= class_d;
      ccnt_q     <= ccnt_d;
      nospk_q    <= nospk_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign class_out    = class_q;
  assign class_count  = ccnt_q;
  assign no_spike     = nospk_q;

endmodule

// File: tb/tb_spike_window_decoder.sv
module tb_spike_window_decoder;

  localparam int N   = 8;
  localparam int WIN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start;
  logic       spike_valid;
  logic       result_ready;
  logic [7:0] spike_in;
  logic       sel;  // 0: default DUT (CNT_W=8), 1: narrow DUT (CNT_W=4)

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic       busy_a, rv_a, ns_a;
  logic [2:0] cls_a;
  logic [7:0] cc_a;
  logic       busy_b, rv_b, ns_b;
  logic [2:0] cls_b;
  logic [3:0] cc_b;

  spike_window_decoder u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_a),
    .spike_in     (spike_in),
    .spike_valid  (spike_valid),
    .busy         (busy_a),
    .result_valid (rv_a),
    .result_ready (result_ready),
    .class_out    (cls_a),
    .class_count  (cc_a),
    .no_spike     (ns_a)
  );

  spike_window_decoder #(.CNT_W(4)) u_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_b),
    .spike_in     (spike_in),
    .spike_valid  (spike_valid),
    .busy         (busy_b),
    .result_valid (rv_b),
    .result_ready (result_ready),
    .class_out    (cls_b),
    .class_count  (cc_b),
    .no_spike     (ns_b)
  );

  logic       busy_m, rv_m, ns_m;
  logic [2:0] cls_m;
  logic [7:0] cc_m;
  assign busy_m = sel ? busy_b : busy_a;
  assign rv_m   = sel ? rv_b   : rv_a;
  assign ns_m   = sel ? ns_b   : ns_a;
  assign cls_m  = sel ? cls_b  : cls_a;
  assign cc_m   = sel ? {4'b0000, cc_b} : cc_a;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a window is just 16 spike vectors; per-neuron counts are
  // plain sums clipped at the counter ceiling, the winner is the lowest index
  // holding the maximum.
  logic [7:0] vec [WIN];
  int exp_cls, exp_cnt;
  bit exp_ns;

  task automatic model(input int cmax);
    int cnt [N];
    for (int i = 0; i < N; i++) begin
      int s = 0;
      for (int j = 0; j < WIN; j++) s += int'(vec[j][i]);
      cnt[i] = (s > cmax) ? cmax : s;
    end
    exp_cnt = 0;
    for (int i = 0; i < N; i++) if (cnt[i] > exp_cnt) exp_cnt = cnt[i];
    exp_cls = 0;
    for (int i = N - 1; i >= 0; i--) if (cnt[i] == exp_cnt) exp_cls = i;
    exp_ns = (exp_cnt == 0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_state"}, {31'd0, busy_m, rv_m} , 32'd1);
    chk({tag, "_class"}, 32'(cls_m), 32'(exp_cls));
    chk({tag, "_count"}, 32'(cc_m), 32'(exp_cnt));
    chk({tag, "_nospike"}, 32'(ns_m), 32'(exp_ns));
  endtask

  // Runs one window from IDLE. Starts and ends just after a falling edge.
  // gap_mode: 0 = valid every cycle, 1 = alternate cycles, 2 = random gaps.
  task automatic run_window(input logic s, input int gap_mode, input int hold_cycles);
    int  idx = 0;
    int  guard = 0;
    bit  tog = 1'b0;
    bit  v;
    sel = s;
    model(s ? 15 : 255);
    chk("idle_state", {30'd0, busy_m, rv_m}, 32'd0);
    // Samples offered in the start cycle must not be counted.
    start = 1'b1; spike_valid = 1'b1; spike_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("count_busy", 32'(busy_m), 32'd1);
    while (idx < WIN && guard < 400) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      spike_valid = v;
      spike_in    = v ? vec[idx] : 8'($urandom);
      if (v) idx++;
      guard++;
      @(negedge clk);
      if (idx < WIN) chk("window_open", {30'd0, busy_m, rv_m}, 32'd2);
    end
    if (guard >= 400) chk("feed_bound", 32'd0, 32'd1);
    // Now in cycle k+1 after the last sample; junk samples here are ignored.
    spike_valid  = 1'b1;
    spike_in     = 8'($urandom);
    result_ready = (hold_cycles == 0);
    for (int c = 1; c <= N; c++) begin
      chk("argmax_phase", {30'd0, busy_m, rv_m}, 32'd2);
      @(negedge clk);
    end
    spike_valid = 1'b0;
    check_result("hold");
    for (int i = 0; i < hold_cycles; i++) begin
      start = (i == 1);
      @(negedge clk);
      start = 1'b0;
      check_result("hold_stable");
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("released", {30'd0, busy_m, rv_m}, 32'd0);
    result_ready = 1'b0;
    @(negedge clk);
    chk("stay_idle", {30'd0, busy_m, rv_m}, 32'd0);
  endtask

  task automatic rand_vec(input int density);
    for (int j = 0; j < WIN; j++) begin
      logic [7:0] b = 8'd0;
      for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 99) < density);
      vec[j] = b;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; spike_valid = 1'b0; result_ready = 1'b0;
    spike_in = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    chk("rst_valid", 32'({rv_a, rv_b}), 32'd0);
    chk("rst_class", 32'({cls_a, cls_b}), 32'd0);
    chk("rst_count", 32'({cc_a, cc_b}), 32'd0);
    chk("rst_nospike", 32'({ns_a, ns_b}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic: neuron 2 fires on 10 of the 16 steps.
    for (int j = 0; j < WIN; j++) vec[j] = (((j * 7) % 16) < 10) ? 8'h04 : 8'h00;
    run_window(1'b0, 0, 0);

    // Tie with gaps: neurons 3 and 5 both reach 7; lower index wins.
    for (int j = 0; j < WIN; j++)
      vec[j] = ((j < 7) ? 8'h08 : 8'h00) | ((j >= 9) ? 8'h20 : 8'h00);
    run_window(1'b0, 1, 0);

    // Saturation on the 4-bit DUT: every neuron hits 16, clipped at 15.
    for (int j = 0; j < WIN; j++) vec[j] = 8'hFF;
    run_window(1'b1, 0, 0);

    // Empty window.
    for (int j = 0; j < WIN; j++) vec[j] = 8'h00;
    run_window(1'b0, 0, 1);

    // Backpressure with a start pulse during HOLD.
    rand_vec(40);
    run_window(1'b0, 2, 5);

    // Reset in the middle of a window.
    sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spike_valid = 1'b1; spike_in = 8'hFF;
    repeat (8) @(negedge clk);
    spike_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", {30'd0, busy_a, rv_a}, 32'd0);
    chk("midrst_outs", {20'd0, cls_a, cc_a, ns_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rand_vec(30);
    run_window(1'b0, 0, 0);

    // Random windows on both DUTs.
    for (int r = 0; r < 10; r++) begin
      rand_vec($urandom_range(0, 95));
      run_window(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
